// File: rtl/uart_rx_fifo.sv
// UART receiver with input synchroniser, error flags and a show-ahead receive FIFO.
// Latency: a word reaches rd_data one cycle after the last stop-bit mid-sample.
// Backpressure: none on the line; a good word arriving while the FIFO is full (and not popped) is dropped.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   rx                asynchronous serial line, idle high
//   rx_en             receiver enable; low aborts any frame in progress
//   rd_en             pop the FIFO head (ignored while empty)
//   rd_data/rd_valid  FIFO head word / FIFO non-empty
//   fifo_count        number of stored words
//   frame_err, parity_err, overrun_err   sticky error flags
//   err_clr           clears all three sticky flags (wins over a same-cycle set)
//   rx_busy           receiver is inside a frame
//
// Build option: define UART_RX_MAJORITY_EN to take each bit as the 2-of-3
// majority of three samples around the bit centre instead of a single sample.
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    input  logic                          rx_en,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun_err,
    input  logic                          err_clr,
    output logic                          rx_busy
);

    localparam int CYCLE = CLK_FREQ / BAUD_RATE;
    localparam int CW    = $clog2(CYCLE);
    localparam int BW    = $clog2(DATA_BITS + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);

    // Decision points of the cycle counter. In the start bit the decision is
    // at the bit centre; every later bit is decided one full bit period after
    // the previous decision, i.e. at count CYCLE-1 after the counter cleared.
`ifdef UART_RX_MAJORITY_EN
    localparam int HALF_DEC = CYCLE / 2;
`else
    localparam int HALF_DEC = CYCLE / 2 - 1;
`endif
    localparam int FULL_DEC = CYCLE - 1;

    localparam logic [CW-1:0]   C_HALF      = CW'(HALF_DEC);
    localparam logic [CW-1:0]   C_FULL      = CW'(FULL_DEC);
    localparam logic [BW-1:0]   C_LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0]   C_LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic [AW:0]     C_DEPTH     = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;
    logic w_rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    // ------------------------------------------------------------------
    // Receiver state and counters
    // ------------------------------------------------------------------
    state_t               r_state;
    state_t               w_state_nxt;
    logic [CW-1:0]        r_cnt;
    logic [BW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bad;
    logic                 r_stop_bad;

    logic                 w_tick;
    logic [CW-1:0]        w_dec;
    logic                 w_bit;
    logic                 w_par_xor;
    logic                 w_par_mismatch;
    logic                 w_frame_bad;
    logic                 w_push;
    logic                 w_ferr_set;
    logic                 w_perr_set;

    assign w_dec  = (r_state == S_START) ? C_HALF : C_FULL;
    assign w_tick = (r_state != S_IDLE) && (r_cnt == w_dec);

`ifdef UART_RX_MAJORITY_EN
    // Two early samples are held; the third is the live line at the decision.
    logic [1:0] r_maj;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_maj <= 2'b11;
        end else begin
            if (r_cnt == w_dec - CW'(2)) r_maj[0] <= w_rx_s;
            if (r_cnt == w_dec - CW'(1)) r_maj[1] <= w_rx_s;
        end
    end

    assign w_bit = (r_maj[0] & r_maj[1]) | (r_maj[0] & w_rx_s) | (r_maj[1] & w_rx_s);
`else
    assign w_bit = w_rx_s;
`endif

    // Odd parity wants data^parity == 1, even wants 0.
    assign w_par_xor      = ^{r_shift, w_bit};
    assign w_par_mismatch = (PARITY == 1) ? ~w_par_xor : w_par_xor;

    assign w_frame_bad    = r_stop_bad | ~w_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_ferr_set  = 1'b0;
        w_perr_set  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (rx_en && !w_rx_s) w_state_nxt = S_START;
            end
            S_START: begin
                // A line back high at the centre is a glitch, not a start bit.
                if (w_tick) w_state_nxt = w_bit ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_tick && (r_bit == C_LAST_DATA)) begin
                    w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_tick) w_state_nxt = S_STOP;
            end
            S_STOP: begin
                // Leave on the last stop-bit centre so the remaining half bit
                // is spent in IDLE and a back-to-back start edge is seen.
                if (w_tick && (r_bit == C_LAST_STOP)) begin
                    w_state_nxt = S_IDLE;
                    w_ferr_set  = w_frame_bad;
                    w_perr_set  = r_par_bad;
                    w_push      = ~(w_frame_bad | r_par_bad);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Disabling the receiver abandons the frame silently.
        if (!rx_en && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_push      = 1'b0;
            w_ferr_set  = 1'b0;
            w_perr_set  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_par_bad  <= 1'b0;
            r_stop_bad <= 1'b0;
        end else begin
            if ((w_state_nxt != r_state) || (r_state == S_IDLE)) begin
                r_cnt <= '0;
                r_bit <= '0;
            end else if (w_tick) begin
                r_cnt <= '0;
                r_bit <= r_bit + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            // LSB arrives first, so shift in from the top.
            if (w_tick && (r_state == S_DATA)) begin
                r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
            end

            if (r_state == S_IDLE) begin
                r_par_bad  <= 1'b0;
                r_stop_bad <= 1'b0;
            end else begin
                if (w_tick && (r_state == S_PARITY)) r_par_bad <= w_par_mismatch;
                if (w_tick && (r_state == S_STOP) && !w_bit) r_stop_bad <= 1'b1;
            end
        end
    end

    assign rx_busy = (r_state != S_IDLE);

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_count;

    logic                 w_full;
    logic                 w_pop;
    logic                 w_wr;
    logic                 w_ovr;

    assign w_full = (r_count == C_DEPTH);
    assign w_pop  = rd_en && (r_count != '0);
    // A simultaneous pop frees the slot, so a push into a full FIFO is kept.
    assign w_wr   = w_push && (!w_full || w_pop);
    assign w_ovr  = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; rd_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= r_shift;
    end

    assign rd_valid   = (r_count != '0);
    assign rd_data    = rd_valid ? r_mem[r_rd_ptr] : '0;
    assign fifo_count = r_count;

    // ------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------
    logic r_frame_err;
    logic r_parity_err;
    logic r_overrun_err;

    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            r_frame_err   <= 1'b0;
            r_parity_err  <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_frame_err   <= r_frame_err   | w_ferr_set;
            r_parity_err  <= r_parity_err  | w_perr_set;
            r_overrun_err <= r_overrun_err | w_ovr;
        end
    end

    assign frame_err   = r_frame_err;
    assign parity_err  = r_parity_err;
    assign overrun_err = r_overrun_err;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: three receivers (8N1 depth 4, 7E1, 9N2) at 16 clocks per bit.
// Expected words are queued as frames are driven and compared as the FIFO is read.
// All stimulus changes on the falling clock edge; outputs are sampled there too.
module tb_uart_rx_fifo;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic rx_v [3];
    logic en_v [3];
    logic rden_v [3];
    logic clr_v [3];

    logic [7:0] d0;
    logic [6:0] d1;
    logic [8:0] d2;
    logic [2:0] c0;
    logic [4:0] c1, c2;
    logic v0, v1, v2, fe0, fe1, fe2, pe0, pe1, pe2, oe0, oe1, oe2, b0, b1, b2;

    uart_rx_fifo #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                   .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .rx(rx_v[0]), .rx_en(en_v[0]), .rd_en(rden_v[0]),
        .rd_data(d0), .rd_valid(v0), .fifo_count(c0), .frame_err(fe0),
        .parity_err(pe0), .overrun_err(oe0), .err_clr(clr_v[0]), .rx_busy(b0));

    uart_rx_fifo #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(7),
                   .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u1 (
        .clk(clk), .rst(rst), .rx(rx_v[1]), .rx_en(en_v[1]), .rd_en(rden_v[1]),
        .rd_data(d1), .rd_valid(v1), .fifo_count(c1), .frame_err(fe1),
        .parity_err(pe1), .overrun_err(oe1), .err_clr(clr_v[1]), .rx_busy(b1));

    uart_rx_fifo #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(9),
                   .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16)) u2 (
        .clk(clk), .rst(rst), .rx(rx_v[2]), .rx_en(en_v[2]), .rd_en(rden_v[2]),
        .rd_data(d2), .rd_valid(v2), .fifo_count(c2), .frame_err(fe2),
        .parity_err(pe2), .overrun_err(oe2), .err_clr(clr_v[2]), .rx_busy(b2));

    logic [8:0] dat_w [3];
    logic [4:0] cnt_w [3];
    logic       vld_w [3];
    logic       fe_w  [3];
    logic       pe_w  [3];
    logic       oe_w  [3];
    logic       bsy_w [3];

    assign dat_w[0] = {1'b0, d0};
    assign dat_w[1] = {2'b0, d1};
    assign dat_w[2] = d2;
    assign cnt_w[0] = {2'b0, c0};
    assign cnt_w[1] = c1;
    assign cnt_w[2] = c2;
    assign vld_w[0] = v0;  assign vld_w[1] = v1;  assign vld_w[2] = v2;
    assign fe_w[0]  = fe0; assign fe_w[1]  = fe1; assign fe_w[2]  = fe2;
    assign pe_w[0]  = pe0; assign pe_w[1]  = pe1; assign pe_w[2]  = pe2;
    assign oe_w[0]  = oe0; assign oe_w[1]  = oe1; assign oe_w[2]  = oe2;
    assign bsy_w[0] = b0;  assign bsy_w[1] = b1;  assign bsy_w[2] = b2;

    int n_tot = 0;
    int n_bad = 0;
    logic [8:0] sb [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int depth_of(input int u);
        return (u == 0) ? 4 : 16;
    endfunction
    function automatic int nbits_of(input int u);
        return (u == 0) ? 8 : ((u == 1) ? 7 : 9);
    endfunction
    function automatic int par_of(input int u);
        return (u == 1) ? 2 : 0;
    endfunction
    function automatic int nstop_of(input int u);
        return (u == 2) ? 2 : 1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clr(input int u);
        clr_v[u] = 1'b1;
        tick(1);
        clr_v[u] = 1'b0;
    endtask

    // Drive one frame, 16 clocks per bit. The last stop-bit centre, where the
    // receiver pushes, falls on posedge 11+16*(frame_bits-1) counted from the
    // first posedge after the start edge. With pop_on_push, rd_en is held
    // high over exactly that edge.
    task automatic send(input int u, input logic [8:0] d, input bit bad_par,
                        input bit stop_last_low, input bit pop_on_push);
        int nb, np, ns, f, push_at, c;
        logic [15:0] frame;
        logic x, p;
        logic [8:0] e;
        nb = nbits_of(u);
        np = (par_of(u) != 0) ? 1 : 0;
        ns = nstop_of(u);
        f  = 1 + nb + np + ns;
        frame = '1;
        frame[0] = 1'b0;
        x = 1'b0;
        for (int i = 0; i < nb; i++) begin
            frame[1+i] = d[i];
            x = x ^ d[i];
        end
        if (np != 0) begin
            p = (par_of(u) == 1) ? ~x : x;
            frame[1+nb] = bad_par ? ~p : p;
        end
        if (stop_last_low) frame[f-1] = 1'b0;
        push_at = 11 + 16 * (f - 1);
        c = 0;
        for (int b = 0; b < f; b++) begin
            rx_v[u] = frame[b];
            repeat (16) begin
                if (pop_on_push && c == push_at - 1) begin
                    e = sb.pop_front();
                    check("pop_vld", vld_w[u], 1);
                    check("pop_dat", dat_w[u], e);
                    rden_v[u] = 1'b1;
                end
                if (pop_on_push && c == push_at) rden_v[u] = 1'b0;
                @(negedge clk);
                c++;
            end
        end
        rx_v[u] = 1'b1;
        if (!bad_par && !stop_last_low && sb.size() < depth_of(u)) sb.push_back(d);
    endtask

    task automatic drain(input int u);
        logic [8:0] e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check("rd_vld", vld_w[u], 1);
            check("rd_dat", dat_w[u], e);
            rden_v[u] = 1'b1;
            tick(1);
            rden_v[u] = 1'b0;
        end
        check("empty_vld", vld_w[u], 0);
        check("empty_cnt", cnt_w[u], 0);
    endtask

    task automatic check_quiet(input int u, input string tag);
        check({tag, "_busy"}, bsy_w[u], 0);
        check({tag, "_fe"},   fe_w[u], 0);
        check({tag, "_pe"},   pe_w[u], 0);
        check({tag, "_oe"},   oe_w[u], 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $display("test done: total=%0d bad=%0d", n_tot, n_bad + 1);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            rx_v[i] = 1'b1; en_v[i] = 1'b1; rden_v[i] = 1'b0; clr_v[i] = 1'b0;
        end
        rst = 1'b1;
        tick(4);
        for (int i = 0; i < 3; i++) begin
            check("rst_vld", vld_w[i], 0);
            check("rst_cnt", cnt_w[i], 0);
            check("rst_dat", dat_w[i], 0);
            check_quiet(i, "rst");
        end
        rst = 1'b0;
        tick(4);

        // 8N1 back-to-back frames
        send(0, 9'h0A5, 0, 0, 0);
        send(0, 9'h03C, 0, 0, 0);
        check("b2b_cnt", cnt_w[0], 2);
        check_quiet(0, "b2b");
        drain(0);
        rden_v[0] = 1'b1;
        tick(1);
        rden_v[0] = 1'b0;
        check("rd_empty_cnt", cnt_w[0], 0);
        check("rd_empty_vld", vld_w[0], 0);

        // stop bit low
        send(0, 9'h055, 0, 1, 0);
        tick(20);
        check("ferr_set", fe_w[0], 1);
        check("ferr_cnt", cnt_w[0], 0);
        pulse_clr(0);
        check("ferr_clr", fe_w[0], 0);

        // 4-cycle glitch on idle line
        rx_v[0] = 1'b0;
        tick(4);
        rx_v[0] = 1'b1;
        tick(2);
        check("glitch_busy", bsy_w[0], 1);
        tick(20);
        check("glitch_cnt", cnt_w[0], 0);
        check_quiet(0, "glitch");

        // overrun: fifth word dropped
        for (int i = 1; i <= 5; i++) send(0, 9'(8'h11 * i), 0, 0, 0);
        check("ovr_cnt", cnt_w[0], 4);
        check("ovr_set", oe_w[0], 1);
        drain(0);
        pulse_clr(0);
        check("ovr_clr", oe_w[0], 0);

        // fifth word pushed while popping: accepted
        for (int i = 1; i <= 4; i++) send(0, 9'(8'h60 + i), 0, 0, 0);
        send(0, 9'h065, 0, 0, 1);
        check("pp_cnt", cnt_w[0], 4);
        check("pp_ovr", oe_w[0], 0);
        drain(0);

        // rx_en dropped after the third data bit
        send(0, 9'h07E, 0, 0, 0);
        for (int c = 0; c < 60; c++) begin
            rx_v[0] = ((c / 16) == 0 || (c / 16) == 2) ? 1'b0 : 1'b1;
            tick(1);
        end
        check("en_busy_before", bsy_w[0], 1);
        en_v[0] = 1'b0;
        rx_v[0] = 1'b1;
        tick(1);
        check("en_busy_after", bsy_w[0], 0);
        tick(200);
        check("en_cnt", cnt_w[0], 1);
        check_quiet(0, "en");
        en_v[0] = 1'b1;
        tick(2);
        drain(0);

        // reset in the middle of a frame
        send(0, 9'h055, 0, 1, 0);
        tick(20);
        send(0, 9'h012, 0, 0, 0);
        check("pre_rst_fe", fe_w[0], 1);
        check("pre_rst_cnt", cnt_w[0], 1);
        rx_v[0] = 1'b0;
        tick(40);
        check("pre_rst_busy", bsy_w[0], 1);
        rst = 1'b1;
        tick(1);
        check("mrst_vld", vld_w[0], 0);
        check("mrst_cnt", cnt_w[0], 0);
        check("mrst_dat", dat_w[0], 0);
        check_quiet(0, "mrst");
        rst = 1'b0;
        rx_v[0] = 1'b1;
        sb.delete();
        tick(20);

        // 7E1: bad parity, clear, then good word
        send(1, 9'h041, 1, 0, 0);
        tick(5);
        check("perr_set", pe_w[1], 1);
        check("perr_cnt", cnt_w[1], 0);
        check("perr_fe", fe_w[1], 0);
        pulse_clr(1);
        check("perr_clr", pe_w[1], 0);
        send(1, 9'h041, 0, 0, 0);
        check("par_ok_cnt", cnt_w[1], 1);
        check("par_ok_pe", pe_w[1], 0);
        drain(1);

        // 9N2
        send(2, 9'h1FF, 0, 0, 0);
        send(2, 9'h000, 0, 0, 0);
        check("n2_cnt", cnt_w[2], 2);
        check("n2_fe", fe_w[2], 0);
        drain(2);
        send(2, 9'h0AA, 0, 1, 0);
        tick(20);
        check("n2_ferr", fe_w[2], 1);
        check("n2_ferr_cnt", cnt_w[2], 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 receiver.
- Configurable data width, parity and stop-bit count.
- Input synchroniser and false-start rejection.
- Error detection with sticky error flags.
- Show-ahead receive FIFO, so the core no longer polls and acknowledges one byte at a time.
- Sits between the board RX pin and the peripheral-bus register block.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD_RATE, 115_200: line rate. CYCLE = CLK_FREQ/BAUD_RATE (integer division, must be ≥ 8).
- DATA_BITS, 8: data bits per frame, legal 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: legal 1 or 2.
- FIFO_DEPTH, 16: entries, power of two, ≥ 2.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous active-high reset.
- rx, input, 1: asynchronous serial line, idle high.
- rx_en, input, 1: receiver enable.
- rd_en, input, 1: pop the FIFO head.
- rd_data, output, DATA_BITS: FIFO head word, valid while rd_valid is high.
- rd_valid, output, 1: FIFO non-empty.
- fifo_count, output, $clog2(FIFO_DEPTH)+1: current number of stored words.
- frame_err, output, 1: sticky; a stop bit was sampled low.
- parity_err, output, 1: sticky; parity mismatch.
- overrun_err, output, 1: sticky; a good word arrived while the FIFO was full.
- err_clr, input, 1: clears all three sticky flags.
- rx_busy, output, 1: state ≠ IDLE.

Behaviour:
- Reset: rst is synchronous and active-high on clk.
  - rd_data = 0, rd_valid = 0, fifo_count = 0.
  - All error flags = 0, rx_busy = 0.
  - State = IDLE; synchroniser flops are preset to 1.
- Input path: rx passes through a 2-flop synchroniser giving rx_s. All decisions use rx_s only.
- Counters:
  - Cycle counter is $clog2(CYCLE) bits wide and clears on every state change.
  - Bit counter is $clog2(DATA_BITS+1) bits wide.
- State machine:
  - IDLE → START when rx_en = 1 and rx_s = 0.
  - START: at cycle count CYCLE/2-1, sample the line.
    - Sample = 1: false start, return to IDLE with no flag and no push.
    - Sample = 0: restart the count and go to DATA.
  - DATA: sample at each full CYCLE from the start-bit midpoint, LSB first, into a DATA_BITS shift register. After DATA_BITS samples, go to PARITY if PARITY ≠ 0, else go to STOP.
  - PARITY: one sample. Odd parity requires the XOR of data and parity bit = 1; even parity requires it = 0.
  - STOP: STOP_BITS samples. Any stop sample equal to 0 is a frame error.
  - Return to IDLE on the cycle of the last stop-bit mid-sample. The remaining half bit is spent in IDLE, so a back-to-back start edge is caught.
- Push decision, made on the last stop-sample cycle:
  - No parity or frame error: push the word.
  - Any error: set the matching flag(s) and discard the word.
  - Word and flags update on the same clock edge.
- FIFO:
  - Show-ahead: rd_data always shows the head word.
  - A pushed word is visible on rd_data, with rd_valid = 1, one cycle after the push edge.
  - rd_en with rd_valid = 1 pops on that edge. rd_en while empty is ignored.
  - Push and pop in the same cycle: both take effect and fifo_count is unchanged. This also applies when the FIFO is full, and the push is accepted.
  - Push while full with no pop: word dropped, overrun_err = 1.
  - Pointers wrap modulo FIFO_DEPTH.
- Flags: err_clr takes priority over a simultaneous flag set; the clear wins for that cycle only.
- rx_en deasserted mid-frame: the next edge forces IDLE.
  - Partial frame discarded, no flags set.
  - FIFO contents and reads are unaffected.
- rst mid-frame: the reset rules above apply; FIFO contents are lost.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- When defined: each bit (start, data, parity, stop) is the 2-of-3 majority of rx_s at cycle counts CYCLE/2-2, CYCLE/2-1 and CYCLE/2. The decision is taken at CYCLE/2, so the IDLE return and the push move one cycle later.
- When not defined: a single sample at CYCLE/2-1.

Test Plan:
- 8N1, CYCLE=16: send 0xA5 then 0x3C back-to-back → both words in the FIFO in order, fifo_count=2, no flags set; rd_en pops 0xA5, then 0x3C, then rd_valid=0.
- PARITY=2, DATA_BITS=7: send 0x41 with a wrong parity bit → parity_err=1, fifo_count stays 0; err_clr for one cycle → flag clears; then send a valid 0x41 → stored.
- Stop bit driven low on 0x55 → frame_err=1, no push. A 4-cycle low glitch on an idle line → returns to IDLE, nothing pushed, no flags.
- FIFO_DEPTH=4: send 5 words with no reads → first 4 words stored, 5th dropped, overrun_err=1. Repeat with rd_en asserted on the 5th push cycle → 5th word accepted, count stays 4, no overrun.
- STOP_BITS=2, DATA_BITS=9: send 0x1FF then 0x000 → both stored correctly; a second stop bit of 0 → frame_err=1.
- Drop rx_en after the 3rd data bit → IDLE next cycle, nothing pushed, no flags. Assert rst mid-frame → all outputs return to their reset values.
